// File: rtl/secded_prot_regfile.sv
// SEC-DED protected register file: extended Hamming storage, 1-cycle corrected reads,
// background scrubber with writeback, saturating SEC/DED counters and fault injection.
module secded_prot_regfile #(
  parameter int DATA_WIDTH   = 11,
  parameter int DEPTH        = 8,
  parameter int CNT_WIDTH    = 8,
  parameter int SCRUB_PERIOD = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int P  = (DATA_WIDTH <= 1)  ? 2 :
                      (DATA_WIDTH <= 4)  ? 3 :
                      (DATA_WIDTH <= 11) ? 4 :
                      (DATA_WIDTH <= 26) ? 5 :
                      (DATA_WIDTH <= 57) ? 6 : 7,
  localparam int CW = DATA_WIDTH + P + 1
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o,
  output logic                  rsec_o,
  output logic                  rded_o,
  input  logic                  inj_en_i,
  input  logic [AW-1:0]         inj_addr_i,
  input  logic [CW-1:0]         inj_mask_i,
  input  logic                  err_clr_i,
  output logic [CNT_WIDTH-1:0]  sec_cnt_o,
  output logic [CNT_WIDTH-1:0]  ded_cnt_o,
  output logic                  ded_sticky_o,
  output logic [AW-1:0]         ded_addr_o,
  output logic                  scrub_busy_o
);

  // state | meaning
  // WAIT  | idle countdown between scrub checks
  // CHECK | decode entry[ptr], count its errors
  // FIX   | write corrected codeword back to entry[ptr]
  localparam logic [1:0] S_WAIT  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_FIX   = 2'd2;

  localparam int TW = $clog2(SCRUB_PERIOD + 1);
  localparam logic [TW-1:0] TMAX = TW'(SCRUB_PERIOD - 1);

  function automatic logic [CW-1:0] encode(input logic [DATA_WIDTH-1:0] d);
    logic [CW-1:0] c;
    int j;
    c = '0;
    j = 0;
    for (int i = 1; i < CW; i++) begin
      if ((i & (i - 1)) != 0) begin
        c[i] = d[j];
        j++;
      end
    end
    for (int k = 0; k < P; k++) begin
      for (int i = 1; i < CW; i++) begin
        if (((i >> k) & 1) == 1 && (i & (i - 1)) != 0) c[1 << k] ^= c[i];
      end
    end
    c[0] = ^c[CW-1:1];
    return c;
  endfunction

  function automatic logic [P-1:0] syndrome(input logic [CW-1:0] c);
    logic [P-1:0] s;
    s = '0;
    for (int i = 1; i < CW; i++) begin
      if (c[i]) s ^= P'(i);
    end
    return s;
  endfunction

  // q=1 means an odd number of flips; syndrome 0 then points at the overall parity bit
  function automatic logic [CW-1:0] correct(input logic [CW-1:0] c);
    logic [CW-1:0] f;
    logic [P-1:0] s;
    s = syndrome(c);
    f = c;
    for (int i = 0; i < CW; i++) begin
      if ((^c) && s == P'(i)) f[i] = ~c[i];
    end
    return f;
  endfunction

  function automatic logic [1:0] classify(input logic [CW-1:0] c);
    logic q;
    q = ^c;
    return {q, (syndrome(c) != '0) && !q};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] extract(input logic [CW-1:0] c);
    logic [DATA_WIDTH-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int i = 1; i < CW; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[j] = c[i];
        j++;
      end
    end
    return d;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] base,
                                                   input logic a, input logic b);
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, base} + {{CNT_WIDTH{1'b0}}, a} + {{CNT_WIDTH{1'b0}}, b};
    return sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
  endfunction

  logic [CW-1:0] mem [DEPTH];
  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic [AW-1:0] ptr, ptr_nxt;
  logic [CW-1:0] wr_cw, rd_cw, sc_cw, sc_fix;
  logic [1:0]    rd_cls, sc_cls;
  logic          fix_wr, rd_sec_ev, rd_ded_ev, sc_sec_ev, sc_ded_ev;

  assign wr_cw     = encode(wdata_i);
  assign rd_cw     = mem[raddr_i];
  assign rd_cls    = classify(rd_cw);
  assign sc_cw     = mem[ptr];
  assign sc_cls    = classify(sc_cw);
  assign sc_fix    = correct(sc_cw);
  assign ptr_nxt   = (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
  assign fix_wr    = (state == S_FIX) && !(we_i && waddr_i == ptr) &&
                     !(inj_en_i && inj_addr_i == ptr);
  assign rd_sec_ev = re_i && rd_cls[1];
  assign rd_ded_ev = re_i && rd_cls[0];
  assign sc_sec_ev = (state == S_CHECK) && sc_cls[1];
  assign sc_ded_ev = (state == S_CHECK) && sc_cls[0];
  assign scrub_busy_o = (state == S_CHECK) || (state == S_FIX);

  // user write/injection always override a pending scrub writeback
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (inj_en_i && inj_addr_i == AW'(i))
          mem[i] <= ((we_i && waddr_i == AW'(i)) ? wr_cw : mem[i]) ^ inj_mask_i;
        else if (we_i && waddr_i == AW'(i))
          mem[i] <= wr_cw;
        else if (fix_wr && ptr == AW'(i))
          mem[i] <= sc_fix;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rdata_o  <= '0;
      rvalid_o <= 1'b0;
      rsec_o   <= 1'b0;
      rded_o   <= 1'b0;
    end else begin
      rvalid_o <= re_i;
      rsec_o   <= rd_sec_ev;
      rded_o   <= rd_ded_ev;
      if (re_i) rdata_o <= extract(correct(rd_cw));
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= S_WAIT;
      timer <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        S_WAIT: begin
          if (timer == TMAX) begin
            timer <= '0;
            state <= S_CHECK;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_CHECK: begin
          if (sc_cls[1]) begin
            state <= S_FIX;
          end else begin
            ptr   <= ptr_nxt;
            state <= S_WAIT;
          end
        end
        S_FIX: begin
          ptr   <= ptr_nxt;
          state <= S_WAIT;
        end
        default: state <= S_WAIT;
      endcase
    end
  end

  // clear acts first, so same-cycle events land on a zeroed counter / cleared sticky
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sec_cnt_o    <= '0;
      ded_cnt_o    <= '0;
      ded_sticky_o <= 1'b0;
      ded_addr_o   <= '0;
    end else begin
      sec_cnt_o    <= sat_add(err_clr_i ? '0 : sec_cnt_o, rd_sec_ev, sc_sec_ev);
      ded_cnt_o    <= sat_add(err_clr_i ? '0 : ded_cnt_o, rd_ded_ev, sc_ded_ev);
      ded_sticky_o <= (ded_sticky_o && !err_clr_i) || rd_ded_ev || sc_ded_ev;
      if ((rd_ded_ev || sc_ded_ev) && (err_clr_i || !ded_sticky_o))
        ded_addr_o <= rd_ded_ev ? raddr_i : ptr;
    end
  end

endmodule

// File: tb/tb_secded_prot_regfile.sv
// Directed bench for secded_prot_regfile (DATA_WIDTH=11, CW=16, CNT_WIDTH=2 to reach saturation).
module tb_secded_prot_regfile;
  localparam int DW = 11;
  localparam int AW = 3;
  localparam int CW = 16;
  localparam int CNTW = 2;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            we = 1'b0, re = 1'b0, inj_en = 1'b0, err_clr = 1'b0;
  logic [AW-1:0]   waddr = '0, raddr = '0, inj_addr = '0;
  logic [DW-1:0]   wdata = '0;
  logic [CW-1:0]   inj_mask = '0;
  logic [DW-1:0]   rdata;
  logic            rvalid, rsec, rded, ded_sticky, scrub_busy;
  logic [CNTW-1:0] sec_cnt, ded_cnt;
  logic [AW-1:0]   ded_addr;

  int n_cmp = 0;
  int n_err = 0;

  secded_prot_regfile #(
    .DATA_WIDTH(DW), .DEPTH(8), .CNT_WIDTH(CNTW), .SCRUB_PERIOD(16)
  ) dut (
    .clk_i(clk), .rstn_i(rstn),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .re_i(re), .raddr_i(raddr),
    .rdata_o(rdata), .rvalid_o(rvalid), .rsec_o(rsec), .rded_o(rded),
    .inj_en_i(inj_en), .inj_addr_i(inj_addr), .inj_mask_i(inj_mask),
    .err_clr_i(err_clr),
    .sec_cnt_o(sec_cnt), .ded_cnt_o(ded_cnt),
    .ded_sticky_o(ded_sticky), .ded_addr_o(ded_addr),
    .scrub_busy_o(scrub_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic inj(input logic [AW-1:0] a, input logic [CW-1:0] m);
    inj_en = 1'b1; inj_addr = a; inj_mask = m;
    tick();
    inj_en = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    re = 1'b1; raddr = a;
    tick();
    re = 1'b0;
  endtask

  task automatic clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic check_read(input string tag, input logic [DW-1:0] d,
                            input logic sec, input logic ded);
    chk({tag, "_valid"}, rvalid, 1);
    chk({tag, "_data"}, rdata, d);
    chk({tag, "_sec"}, rsec, sec);
    chk({tag, "_ded"}, rded, ded);
  endtask

  // Align to the start of a WAIT period: the next 16 cycles see no scrub check.
  task automatic sync_scrub();
    int t;
    t = 0;
    while (scrub_busy !== 1'b1 && t < 100) begin tick(); t++; end
    chk("scrub_busy_seen", scrub_busy, 1);
    t = 0;
    while (scrub_busy !== 1'b0 && t < 10) begin tick(); t++; end
    chk("scrub_idle", scrub_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [CW-1:0] dbl [6];
    logic [CNTW-1:0] sat_exp [5];
    dbl = '{16'h0003, 16'h8001, 16'h0006, 16'hC000, 16'h0101, 16'h0018};
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_sec_cnt", sec_cnt, 0);
    chk("rst_ded_cnt", ded_cnt, 0);
    chk("rst_sticky", ded_sticky, 0);
    chk("rst_ded_addr", ded_addr, 0);
    chk("rst_busy", scrub_busy, 0);

    // basic write/read, hold behaviour, reset-cleared memory, codeword layout
    wr(3'd2, 11'h5A3);
    rd(3'd2);
    check_read("t1", 11'h5A3, 0, 0);
    chk("t1_sec_cnt", sec_cnt, 0);
    chk("t1_ded_cnt", ded_cnt, 0);
    tick();
    chk("t1_rvalid_drop", rvalid, 0);
    chk("t1_rdata_hold", rdata, 11'h5A3);
    rd(3'd7);
    check_read("rst_mem", 11'h000, 0, 0);
    inj(3'd0, 16'hB42D);
    rd(3'd0);
    check_read("layout_5a3", 11'h5A3, 0, 0);
    inj(3'd6, 16'hFFFF);
    rd(3'd6);
    check_read("layout_7ff", 11'h7FF, 0, 0);

    // read and write same address in one cycle returns the old word
    wr(3'd3, 11'h111);
    re = 1'b1; raddr = 3'd3; we = 1'b1; waddr = 3'd3; wdata = 11'h222;
    tick();
    re = 1'b0; we = 1'b0;
    check_read("raw_old", 11'h111, 0, 0);
    rd(3'd3);
    check_read("raw_new", 11'h222, 0, 0);

    // single-error correction on data bit and overall parity bit
    sync_scrub();
    clr();
    wr(3'd5, 11'h7FF);
    inj(3'd5, 16'h0400);
    rd(3'd5);
    check_read("sec_b10", 11'h7FF, 1, 0);
    chk("sec_b10_cnt", sec_cnt, 1);
    chk("sec_b10_ded_cnt", ded_cnt, 0);
    wr(3'd5, 11'h7FF);
    inj(3'd5, 16'h0001);
    rd(3'd5);
    check_read("sec_p0", 11'h7FF, 1, 0);
    chk("sec_p0_cnt", sec_cnt, 2);

    // double errors: data returned uncorrected, first DED address kept
    sync_scrub();
    clr();
    wr(3'd1, 11'h123);
    inj(3'd1, 16'h0018);
    rd(3'd1);
    check_read("ded1", 11'h122, 0, 1);
    chk("ded1_sticky", ded_sticky, 1);
    chk("ded1_addr", ded_addr, 1);
    chk("ded1_cnt", ded_cnt, 1);
    wr(3'd3, 11'h0AA);
    inj(3'd3, 16'h0018);
    rd(3'd3);
    check_read("ded3", 11'h0AB, 0, 1);
    chk("ded3_addr_kept", ded_addr, 1);
    chk("ded3_cnt", ded_cnt, 2);
    wr(3'd1, 11'h000);
    wr(3'd3, 11'h000);
    wr(3'd5, 11'h000);

    // scrubber repairs a single flip with no user reads
    sync_scrub();
    clr();
    chk("clr_sticky", ded_sticky, 0);
    chk("clr_ded_cnt", ded_cnt, 0);
    wr(3'd4, 11'h3C5);
    inj(3'd4, 16'h0100);
    repeat (8 * 18) tick();
    rd(3'd4);
    check_read("scrubbed", 11'h3C5, 0, 0);
    chk("scrub_sec_cnt", sec_cnt, 1);
    chk("scrub_ded_cnt", ded_cnt, 0);

    // counter saturation and clear with a same-cycle event
    sync_scrub();
    clr();
    wr(3'd6, 11'h155);
    inj(3'd6, 16'h0040);
    re = 1'b1; raddr = 3'd6;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("sat_cnt_%0d", i), sec_cnt, sat_exp[i]);
    end
    check_read("sat_read", 11'h155, 1, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0; re = 1'b0;
    chk("clr_with_sec", sec_cnt, 1);
    wr(3'd6, 11'h000);

    // flip campaign: no flip, every single flip, several double flips
    we = 1'b1; waddr = 3'd7; wdata = 11'h2B6;
    tick();
    we = 1'b0;
    rd(3'd7);
    check_read("clean", 11'h2B6, 0, 0);
    for (int i = 0; i < CW; i++) begin
      we = 1'b1; waddr = 3'd7; wdata = 11'h2B6;
      inj_en = 1'b1; inj_addr = 3'd7; inj_mask = 16'h0001 << i;
      tick();
      we = 1'b0; inj_en = 1'b0;
      rd(3'd7);
      check_read($sformatf("single_b%0d", i), 11'h2B6, 1, 0);
    end
    for (int i = 0; i < 6; i++) begin
      we = 1'b1; waddr = 3'd7; wdata = 11'h2B6;
      inj_en = 1'b1; inj_addr = 3'd7; inj_mask = dbl[i];
      tick();
      we = 1'b0; inj_en = 1'b0;
      rd(3'd7);
      chk($sformatf("double_%0d_valid", i), rvalid, 1);
      chk($sformatf("double_%0d_sec", i), rsec, 0);
      chk($sformatf("double_%0d_ded", i), rded, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
